axis_uart_tx_fifo_gen: RTL and testbench
========================================

Name: axis_uart_tx_fifo_gen

Overview:
Parametrised successor to the single-register AXI-Stream-to-UART input stage and the fixed 8N1 transmitter. It accepts an AXI-Stream slave byte stream into an internal synchronous FIFO and serialises each entry as a UART frame. Data width, stop bits and FIFO depth are configurable. An idle gap can be inserted after each tlast-terminated packet. It sits between an AXIS master and the uart_tx pin, and feeds the existing UART receiver in loopback.

Parameters:
DATA_BITS, 8, UART data bits per frame (5..9); only tdata[DATA_BITS-1:0] is sent
DEPTH, 16, FIFO entries; power of two, >= 2
CLK_RATE, 50000000, clock frequency in Hz
BAUD, 115200, line rate; BIT_CYC = CLK_RATE/BAUD (integer divide, >= 2)
STOP_BITS, 1, stop bits per frame (1 or 2)
LAST_GAP, 0, idle bit-periods inserted after a frame whose entry had tlast=1

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (asserted when 0)
s_axis_tdata  input  DATA_BITS  payload
s_axis_tvalid  input  1  beat valid
s_axis_tready  output  1  FIFO not full
s_axis_tlast  input  1  packet end; stored with the beat
uart_tx  output  1  serial line; idles high
busy  output  1  frame or gap in progress
fifo_level  output  $clog2(DEPTH)+1  current entry count
overflow_err  output  1  sticky; tvalid seen while tready=0 and FIFO full for > DEPTH*4 cycles is NOT an error; set only by an internal push attempted when full (must never occur)

Behaviour:
- Reset (rst==0 at a clk edge): uart_tx=1, busy=0, fifo_level=0, s_axis_tready=0 during reset and 1 from the first cycle after release, overflow_err=0. The FSM returns to IDLE, the FIFO is emptied and the baud counter is cleared. Reset mid-frame aborts the frame immediately; the line goes high on the next edge.
- Handshake: a beat is accepted when tvalid and tready are both high on a clk edge, and {tlast, tdata} is pushed the same edge. tready = !full. Data and last may change freely while tvalid=0.
- FIFO: circular, with pointers of $clog2(DEPTH)+1 bits (MSB wrap bit). Full when the low bits are equal and the MSBs differ; empty when the pointers are equal. There is no bypass: a push to an empty FIFO is visible to the pop logic the next cycle. A simultaneous push and pop leaves the level unchanged; full cannot block a same-cycle pop.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP, GAP.
  - IDLE: if !empty, pop on this edge, latch data/last into the shift register, go to START. uart_tx drives 0 from the next cycle, so the start bit begins 2 cycles after the accept edge into an idle, empty block.
  - Each state lasts BIT_CYC cycles, timed by a counter 0..BIT_CYC-1 that restarts on every bit.
  - DATA: DATA_BITS bits, LSB first.
  - STOP: uart_tx=1 for STOP_BITS*BIT_CYC cycles.
  - After STOP: go to GAP if latched last==1 and LAST_GAP>0, else to IDLE. GAP holds uart_tx=1 for LAST_GAP*BIT_CYC cycles, then goes to IDLE.
  - Back-to-back: IDLE pops in its first cycle, so an extra idle cycle between frames is allowed (exactly 1 cycle).
- busy=1 in every state except IDLE.
- uart_tx is driven from a register, glitch-free.

Optional Feature:
- AXIS_UART_PARITY_EN. When defined, an input port parity_odd (1 bit, sampled at frame start) is added and a PARITY state follows DATA.
- The parity bit is the XOR of the data bits, inverted when parity_odd=1, and lasts BIT_CYC cycles.
- When undefined, the port and the PARITY state do not exist and the frame goes DATA to STOP directly.

Decomposition:
- Package axis_uart_pkg: FSM state encoding, parity mode constants, a BIT_CYC computation function, and a clog2 helper.
- One sub-module, axis_uart_sfifo (WIDTH=DATA_BITS+1, DEPTH), providing push/pop/full/empty/level.
- The top holds the FSM, baud counter and shift register.

Test Plan:
1. Use CLK_RATE=1000000, BAUD=100000 (BIT_CYC=10), 8N1. Send one beat 0xA5. Required: start bit low 2 cycles after the accept edge, then bits 1,0,1,0,0,1,0,1 each 10 cycles, stop high 10 cycles. The loopback receiver reports 0xA5.
2. Burst of 20 beats with tvalid held high and DEPTH=16. Required: tready drops after the FIFO holds 16; all 20 bytes are transmitted in order with a 1-cycle inter-frame idle; fifo_level never exceeds 16; overflow_err stays 0.
3. LAST_GAP=3, STOP_BITS=2; send 0x11 (last=0), then 0x22 (last=1), then 0x33. Required: 20 high cycles after 0x11, and 20+30 high cycles after 0x22 before the 0x33 start bit.
4. Assert rst=0 during DATA bit 4 of 0x0F. Required: uart_tx=1 and busy=0 on the next edge; fifo_level=0; the next byte after release frames correctly.
5. With AXIS_UART_PARITY_EN and parity_odd=0, send 0x07 then 0x03. Required: parity bits 1 and 0 respectively. With parity_odd=1, send 0x07. Required: parity bit 0.
6. DATA_BITS=5, send 0xFF. Required: exactly 5 data bits of 1 on the line, and 0x1F received.

Source files
------------

// File: rtl/axis_uart_tx_fifo_gen_pkg.sv
// Shared types and helpers for the AXI-Stream to UART transmitter.
// AXIS_UART_PARITY_EN adds the PARITY state to the FSM encoding.
package axis_uart_pkg;

`ifdef AXIS_UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4,
    ST_GAP   = 3'd5
  } uart_state_e;
`endif

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int calc_bit_cyc(input int clk_rate, input int baud);
    return clk_rate / baud;
  endfunction

endpackage

// File: rtl/axis_uart_tx_fifo_gen_if.sv
// AXI-Stream byte channel into the UART transmitter.
// valid/ready: a beat transfers on a rising clk edge where tvalid and tready are both 1;
// tdata/tlast are only meaningful while tvalid=1 and must hold until that edge.
interface axis_uart_tx_fifo_gen_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_uart_sfifo.sv
// Synchronous circular FIFO with wrap-bit pointers; no write-to-read bypass.
module axis_uart_sfifo
  import axis_uart_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [clog2_f(DEPTH):0]   level
);
  localparam int AW = clog2_f(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign level = wr_q - rd_q;
  assign rdata = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push && !full) wr_d = wr_q + PTR_ONE;
    if (pop && !empty) rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/axis_uart_tx_fifo_gen.sv
// AXI-Stream to UART transmitter: FIFO-buffered beats, configurable frame format.
// Optional AXIS_UART_PARITY_EN adds parity_odd and a parity bit after the data bits.
module axis_uart_tx_fifo_gen
  import axis_uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int CLK_RATE  = 50000000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1,
  parameter int LAST_GAP  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef AXIS_UART_PARITY_EN
  input  logic                    parity_odd,
`endif
  axis_uart_tx_fifo_gen_if.slave  s_axis,
  output logic                    uart_tx,
  output logic                    busy,
  output logic [clog2_f(DEPTH):0] fifo_level,
  output logic                    overflow_err,
  output uart_state_e             dbg_state
);
  localparam int BIT_CYC = calc_bit_cyc(CLK_RATE, BAUD);
  localparam int CW      = clog2_f(BIT_CYC);
  localparam int MAXN    = (DATA_BITS > STOP_BITS)
                         ? ((DATA_BITS > LAST_GAP) ? DATA_BITS : LAST_GAP)
                         : ((STOP_BITS > LAST_GAP) ? STOP_BITS : LAST_GAP);
  localparam int BW      = clog2_f(MAXN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 last_q, last_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;
  logic                 ready_en_q, ready_en_d;
`ifdef AXIS_UART_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic                 push, pop, full, empty, tready, bit_end;
  logic [DATA_BITS:0]   fifo_rdata;

  assign tready        = ready_en_q && !full;
  assign s_axis.tready = tready;
  assign push          = s_axis.tvalid && tready;
  assign bit_end       = (cnt_q == CNT_MAX);

  axis_uart_sfifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({s_axis.tlast, s_axis.tdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // tx_d is derived from the current state, so the line trails the FSM by one
  // cycle; every bit keeps its full BIT_CYC length regardless.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + CNT_ONE;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    tx_d       = 1'b1;
    pop        = 1'b0;
    ready_en_d = 1'b1;
    overflow_d = overflow_q | (push && full);
`ifdef AXIS_UART_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rdata[DATA_BITS-1:0];
          last_d  = fifo_rdata[DATA_BITS];
`ifdef AXIS_UART_PARITY_EN
          par_d   = (^fifo_rdata[DATA_BITS-1:0]) ^ (parity_odd == PARITY_ODD);
`endif
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_d = shreg_q[0];
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (int'(bit_q) == DATA_BITS - 1) begin
            bit_d = '0;
`ifdef AXIS_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
`ifdef AXIS_UART_PARITY_EN
      ST_PARITY: begin
        tx_d = par_q;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (int'(bit_q) == STOP_BITS - 1) begin
            bit_d   = '0;
            state_d = (last_q && (LAST_GAP > 0)) ? ST_GAP : ST_IDLE;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          if (int'(bit_q) == LAST_GAP - 1) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      ready_en_q <= 1'b0;
`ifdef AXIS_UART_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      ready_en_q <= ready_en_d;
`ifdef AXIS_UART_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign uart_tx      = tx_q;
  assign busy         = (state_q != ST_IDLE);
  assign overflow_err = overflow_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_axis_uart_tx_fifo_gen.sv
// Directed bench for axis_uart_tx_fifo_gen: three configurations share clk/rst.
// Builds with or without AXIS_UART_PARITY_EN.
module tb_axis_uart_tx_fifo_gen;
  import axis_uart_pkg::*;

  localparam int BIT_CYC = 10;
`ifdef AXIS_UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic par_odd = 1'b0;
  always #5 clk = ~clk;

  axis_uart_tx_fifo_gen_if #(.DATA_BITS(8)) ifa ();
  axis_uart_tx_fifo_gen_if #(.DATA_BITS(8)) ifb ();
  axis_uart_tx_fifo_gen_if #(.DATA_BITS(5)) ifc ();

  logic tx_a, busy_a, ovf_a, tx_b, busy_b, ovf_b, tx_c, busy_c, ovf_c;
  logic [4:0] lvl_a, lvl_b;
  logic [2:0] lvl_c;
  uart_state_e st_a, st_b, st_c;

  // A: 8N1, depth 16, no gap
  axis_uart_tx_fifo_gen #(.DATA_BITS(8), .DEPTH(16), .CLK_RATE(1000000), .BAUD(100000),
                          .STOP_BITS(1), .LAST_GAP(0)) u_a (
    .clk(clk), .rst(rst),
`ifdef AXIS_UART_PARITY_EN
    .parity_odd(par_odd),
`endif
    .s_axis(ifa.slave), .uart_tx(tx_a), .busy(busy_a), .fifo_level(lvl_a),
    .overflow_err(ovf_a), .dbg_state(st_a));

  // B: two stop bits, 3-bit-period gap after tlast
  axis_uart_tx_fifo_gen #(.DATA_BITS(8), .DEPTH(16), .CLK_RATE(1000000), .BAUD(100000),
                          .STOP_BITS(2), .LAST_GAP(3)) u_b (
    .clk(clk), .rst(rst),
`ifdef AXIS_UART_PARITY_EN
    .parity_odd(par_odd),
`endif
    .s_axis(ifb.slave), .uart_tx(tx_b), .busy(busy_b), .fifo_level(lvl_b),
    .overflow_err(ovf_b), .dbg_state(st_b));

  // C: 5 data bits, depth 4
  axis_uart_tx_fifo_gen #(.DATA_BITS(5), .DEPTH(4), .CLK_RATE(1000000), .BAUD(100000),
                          .STOP_BITS(1), .LAST_GAP(0)) u_c (
    .clk(clk), .rst(rst),
`ifdef AXIS_UART_PARITY_EN
    .parity_odd(par_odd),
`endif
    .s_axis(ifc.slave), .uart_tx(tx_c), .busy(busy_c), .fifo_level(lvl_c),
    .overflow_err(ovf_c), .dbg_state(st_c));

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic       last_par;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_of(input int sel);
    case (sel)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic ready_of(input int sel);
    case (sel)
      0:       return ifa.tready;
      1:       return ifb.tready;
      default: return ifc.tready;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic send(input int sel, input logic [7:0] d, input logic l);
    int   g;
    logic rdy;
    case (sel)
      0:       begin ifa.tdata = d;      ifa.tlast = l; ifa.tvalid = 1'b1; end
      1:       begin ifb.tdata = d;      ifb.tlast = l; ifb.tvalid = 1'b1; end
      default: begin ifc.tdata = d[4:0]; ifc.tlast = l; ifc.tvalid = 1'b1; end
    endcase
    g = 0;
    do begin
      rdy = ready_of(sel);
      tick();
      g++;
    end while (!rdy && g < 500);
    chk($sformatf("accept_s%0d", sel), {31'd0, rdy}, 32'd1);
    ifa.tvalid = 1'b0;
    ifb.tvalid = 1'b0;
    ifc.tvalid = 1'b0;
  endtask

  // ---------------- frame checker ----------------
  // Expected data comes from exp_q; every cycle of every bit is compared.
  task automatic rx_frame(input int sel, input string tag);
    int         nb, sb, total, g, bad;
    logic [8:0] exp_d, got;
    logic       fb [16];
    logic       mid [16];
    nb = (sel == 2) ? 5 : 8;
    sb = (sel == 1) ? 2 : 1;
    total = 1 + nb + PAR + sb;
    if (exp_q.size() == 0) begin
      chk({tag, "_exp_empty"}, 32'd0, 32'd1);
      return;
    end
    exp_d = exp_q.pop_front();
    for (int i = 0; i < 16; i++) begin
      fb[i]  = 1'b1;
      mid[i] = 1'b1;
    end
    fb[0] = 1'b0;
    for (int i = 0; i < nb; i++) fb[1 + i] = exp_d[i];
    if (PAR == 1) begin
      fb[1 + nb] = par_odd;
      for (int i = 0; i < nb; i++) fb[1 + nb] = fb[1 + nb] ^ exp_d[i];
    end
    g = 0;
    while (line_of(sel) !== 1'b0 && g < 3000) begin
      tick();
      g++;
    end
    chk({tag, "_start_seen"}, {31'd0, line_of(sel)}, 32'd0);
    if (line_of(sel) !== 1'b0) return;
    for (int b = 0; b < total; b++) begin
      bad = 0;
      for (int c = 0; c < BIT_CYC; c++) begin
        if (b != 0 || c != 0) tick();
        if (line_of(sel) !== fb[b]) bad++;
        if (c == BIT_CYC / 2) mid[b] = line_of(sel);
      end
      chk($sformatf("%s_bit%0d_badcyc", tag, b), bad, 0);
    end
    got = '0;
    for (int i = 0; i < nb; i++) got[i] = mid[1 + i];
    if (PAR == 1) last_par = mid[1 + nb];
    chk({tag, "_rx_data"}, {23'd0, got}, {23'd0, exp_d});
  endtask

  // Counts high cycles after the last checked stop cycle until the next start bit.
  task automatic measure_high(input int sel, output int n);
    n = 0;
    tick();
    while (line_of(sel) === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   n, g, maxlvl;
    logic saw_full, ovf_seen, burst_done, rdy;
    logic [7:0] bdata [20];

    ifa.tvalid = 1'b0; ifa.tdata = '0; ifa.tlast = 1'b0;
    ifb.tvalid = 1'b0; ifb.tdata = '0; ifb.tlast = 1'b0;
    ifc.tvalid = 1'b0; ifc.tdata = '0; ifc.tlast = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_tx",     {31'd0, tx_a},       32'd1);
    chk("rst_busy",   {31'd0, busy_a},     32'd0);
    chk("rst_level",  {27'd0, lvl_a},      32'd0);
    chk("rst_tready", {31'd0, ifa.tready}, 32'd0);
    chk("rst_ovf",    {31'd0, ovf_a},      32'd0);
    rst = 1'b1;
    tick();
    chk("rel_tready", {31'd0, ifa.tready}, 32'd1);
    tick();

    // T1: single 0xA5, start bit two cycles after the accept edge
    exp_q.push_back(9'h0A5);
    send(0, 8'hA5, 1'b0);
    chk("t1_level_after_accept", {27'd0, lvl_a}, 32'd1);
    tick();
    chk("t1_line_before_start", {31'd0, tx_a}, 32'd1);
    chk("t1_busy", {31'd0, busy_a}, 32'd1);
    tick();
    chk("t1_start_at_accept_plus2", {31'd0, tx_a}, 32'd0);
    rx_frame(0, "t1");

    // T2: 20-beat burst with tvalid held high
    for (int i = 0; i < 20; i++) begin
      bdata[i] = 8'(i * 37 + 5);
      exp_q.push_back({1'b0, bdata[i]});
    end
    maxlvl = 0; saw_full = 1'b0; ovf_seen = 1'b0; burst_done = 1'b0;
    repeat (20) tick();
    fork
      begin
        n = 0;
        g = 0;
        ifa.tlast  = 1'b0;
        ifa.tdata  = bdata[0];
        ifa.tvalid = 1'b1;
        while (n < 20 && g < 5000) begin
          rdy = ifa.tready;
          tick();
          g++;
          if (rdy) begin
            n++;
            if (n < 20) ifa.tdata = bdata[n];
          end
        end
        ifa.tvalid = 1'b0;
        chk("t2_all_accepted", n, 20);
      end
      begin
        int gap;
        for (int i = 0; i < 20; i++) begin
          rx_frame(0, $sformatf("t2_f%0d", i));
          if (i < 19) begin
            measure_high(0, gap);
            chk($sformatf("t2_idle_f%0d", i), gap, 1);
          end
        end
        burst_done = 1'b1;
      end
      begin
        while (!burst_done) begin
          @(negedge clk);
          if (int'(lvl_a) > maxlvl) maxlvl = int'(lvl_a);
          if (!ifa.tready && lvl_a == 5'd16) saw_full = 1'b1;
          if (ovf_a) ovf_seen = 1'b1;
        end
      end
    join
    chk("t2_max_level", maxlvl, 16);
    chk("t2_tready_dropped_at_16", {31'd0, saw_full}, 32'd1);
    chk("t2_overflow", {31'd0, ovf_seen}, 32'd0);

    // T3: 2 stop bits, LAST_GAP=3; high runs include the 1-cycle idle before the next pop
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h022);
    exp_q.push_back(9'h033);
    send(1, 8'h11, 1'b0);
    send(1, 8'h22, 1'b1);
    send(1, 8'h33, 1'b0);
    rx_frame(1, "t3_11");
    measure_high(1, n);
    chk("t3_high_after_11", n + 20, 21);
    rx_frame(1, "t3_22");
    measure_high(1, n);
    chk("t3_high_after_22", n + 20, 51);
    rx_frame(1, "t3_33");

    // T4: reset inside data bit 4 of 0x0F
    repeat (5) tick();
    send(0, 8'h0F, 1'b0);
    g = 0;
    while (tx_a !== 1'b0 && g < 50) begin
      tick();
      g++;
    end
    repeat (53) tick();
    chk("t4_line_mid_bit4", {31'd0, tx_a}, 32'd0);
    chk("t4_busy_before", {31'd0, busy_a}, 32'd1);
    rst = 1'b0;
    tick();
    chk("t4_tx_after_rst", {31'd0, tx_a}, 32'd1);
    chk("t4_busy_after_rst", {31'd0, busy_a}, 32'd0);
    chk("t4_level_after_rst", {27'd0, lvl_a}, 32'd0);
    chk("t4_state_after_rst", {29'd0, st_a}, {29'd0, ST_IDLE});
    chk("t4_tready_in_rst", {31'd0, ifa.tready}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("t4_tready_after_rel", {31'd0, ifa.tready}, 32'd1);
    exp_q.push_back(9'h03C);
    send(0, 8'h3C, 1'b0);
    rx_frame(0, "t4_after");

`ifdef AXIS_UART_PARITY_EN
    // T5: parity
    par_odd = 1'b0;
    exp_q.push_back(9'h007);
    send(0, 8'h07, 1'b0);
    rx_frame(0, "t5_07_even");
    chk("t5_par_07_even", {31'd0, last_par}, 32'd1);
    exp_q.push_back(9'h003);
    send(0, 8'h03, 1'b0);
    rx_frame(0, "t5_03_even");
    chk("t5_par_03_even", {31'd0, last_par}, 32'd0);
    par_odd = 1'b1;
    exp_q.push_back(9'h007);
    send(0, 8'h07, 1'b0);
    rx_frame(0, "t5_07_odd");
    chk("t5_par_07_odd", {31'd0, last_par}, 32'd0);
    par_odd = 1'b0;
`endif

    // T6: 5 data bits; the follow-up 0x00 frame pins the frame length
    exp_q.push_back(9'h01F);
    exp_q.push_back(9'h000);
    send(2, 8'hFF, 1'b0);
    send(2, 8'h00, 1'b0);
    rx_frame(2, "t6_ff");
    measure_high(2, n);
    chk("t6_idle_after_5bit", n, 1);
    rx_frame(2, "t6_00");

    chk("final_ovf_a", {31'd0, ovf_a}, 32'd0);
    chk("final_ovf_b", {31'd0, ovf_b}, 32'd0);
    chk("final_ovf_c", {31'd0, ovf_c}, 32'd0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
